// File: rtl/uart_tx.sv
// uart_tx: UART transmitter (8N1 by default), LSB first, paced by the shared mclkx16 enable.
// A one-entry holding register in front of the shifter lets the next frame start
// straight after the stop bit of the current one, with no idle gap on the line.
// Every output is registered, so tx never depends combinationally on an input.

module uart_tx #(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mclkx16,
   input  logic                 tx_load,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_rdy,
   output logic                 tx_busy,
   output logic                 tx
);

   localparam int unsigned TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam int unsigned BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam int unsigned STOP_W = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
   localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_BITS - 1);

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StData,
      StStop
   } state_e;

   state_e               state_q, state_d;
   logic [DATA_BITS-1:0] hold_q, hold_d;
   logic                 hold_full_q, hold_full_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [TICK_W-1:0]    tick_q, tick_d;
   logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic [STOP_W-1:0]    stop_cnt_q, stop_cnt_d;
   logic                 tx_q, tx_d;
   logic                 rdy_q, rdy_d;
   logic                 busy_q, busy_d;

   logic                 load_accept;
   logic                 take_hold;
   logic                 tick_end;

   // Next-state logic: host loads on any edge, serial state only on baud-enable edges.
   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      shift_d     = shift_q;
      tick_d      = tick_q;
      bit_cnt_d   = bit_cnt_q;
      stop_cnt_d  = stop_cnt_q;
      tx_d        = tx_q;
      take_hold   = 1'b0;
      tick_end    = (tick_q == TICK_LAST);

      // rdy_q mirrors an empty hold, so a load can never collide with a transfer.
      load_accept = tx_load & rdy_q;
      if (load_accept) begin
         hold_d      = tx_data;
         hold_full_d = 1'b1;
      end

      if (mclkx16) begin
         tick_d = tick_end ? '0 : tick_q + 1'b1;

         unique case (state_q)
            StIdle: begin
               tick_d = '0;
               if (hold_full_q) begin
                  take_hold = 1'b1;
               end
            end

            StStart: begin
               if (tick_end) begin
                  state_d   = StData;
                  tx_d      = shift_q[0];
                  bit_cnt_d = '0;
               end
            end

            StData: begin
               if (tick_end) begin
                  if (bit_cnt_q == BIT_LAST) begin
                     state_d    = StStop;
                     tx_d       = 1'b1;
                     stop_cnt_d = '0;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 1'b1;
                     shift_d   = shift_q >> 1;
                     tx_d      = shift_q[1];
                  end
               end
            end

            StStop: begin
               if (tick_end) begin
                  if (stop_cnt_q == STOP_LAST) begin
                     // Chain straight into the next start bit when a byte is waiting.
                     if (hold_full_q) begin
                        take_hold = 1'b1;
                     end else begin
                        state_d = StIdle;
                     end
                  end else begin
                     stop_cnt_d = stop_cnt_q + 1'b1;
                  end
               end
            end

            default: begin
               state_d = StIdle;
               tx_d    = 1'b1;
            end
         endcase

         if (take_hold) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            state_d     = StStart;
            tx_d        = 1'b0;
            tick_d      = '0;
         end
      end
   end

   // Status flags are registered alongside the state they describe.
   always_comb begin
      rdy_d  = ~hold_full_d;
      busy_d = (state_d != StIdle) | hold_full_d;
   end

   // State register; reset aborts any frame and returns the line high immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         shift_q     <= '0;
         tick_q      <= '0;
         bit_cnt_q   <= '0;
         stop_cnt_q  <= '0;
         tx_q        <= 1'b1;
         rdy_q       <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         shift_q     <= shift_d;
         tick_q      <= tick_d;
         bit_cnt_q   <= bit_cnt_d;
         stop_cnt_q  <= stop_cnt_d;
         tx_q        <= tx_d;
         rdy_q       <= rdy_d;
         busy_q      <= busy_d;
      end
   end

   assign tx      = tx_q;
   assign tx_rdy  = rdy_q;
   assign tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx. Two instances (8N1 and 7N2) share clk, rst and
// mclkx16; a line monitor per instance rebuilds each frame tick by tick and compares it
// against the ideal waveform of the next expected byte.

module tb_uart_tx;

   localparam int OS = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       mclkx16;
   logic       load0, load1;
   logic [7:0] data0;
   logic [6:0] data1;
   logic       rdy0, busy0, tx0;
   logic       rdy1, busy1, tx1;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp0[$];
   logic [7:0] exp1[$];
   int         starts0[$];
   int         gap_lo = 4;
   int         gap_hi = 4;

   always #5 clk = ~clk;

   uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .OVERSAMPLE(OS)) dut0 (
      .clk    (clk),
      .rst    (rst),
      .mclkx16(mclkx16),
      .tx_load(load0),
      .tx_data(data0),
      .tx_rdy (rdy0),
      .tx_busy(busy0),
      .tx     (tx0)
   );

   uart_tx #(.DATA_BITS(7), .STOP_BITS(2), .OVERSAMPLE(OS)) dut1 (
      .clk    (clk),
      .rst    (rst),
      .mclkx16(mclkx16),
      .tx_load(load1),
      .tx_data(data1),
      .tx_rdy (rdy1),
      .tx_busy(busy1),
      .tx     (tx1)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   // Baud enable: one pulse every gap_lo..gap_hi clocks, driven on the falling edge.
   initial begin
      int ctr = 0;
      mclkx16 = 1'b0;
      forever begin
         @(negedge clk);
         if (ctr == 0) begin
            mclkx16 = 1'b1;
            ctr = $urandom_range(gap_hi, gap_lo) - 1;
         end else begin
            mclkx16 = 1'b0;
            ctr--;
         end
      end
   end

   // Line monitor: ideal frame = OS ticks low, data LSB first OS ticks each, stop ticks high.
   task automatic monitor(input int inst);
      int         db = (inst == 0) ? 8 : 7;
      int         sb = (inst == 0) ? 1 : 2;
      int         fl = (1 + db + sb) * OS;
      bit         smp[$];
      int         ticks = 0;
      int         bad;
      int         avail;
      logic       line;
      logic [7:0] want, got;
      forever begin
         @(posedge clk);
         if (rst) begin
            smp.delete();
            continue;
         end
         if (!mclkx16) continue;
         #1;
         line = (inst == 0) ? tx0 : tx1;
         ticks++;
         if (smp.size() == 0 && line) continue;
         if (smp.size() == 0 && inst == 0) starts0.push_back(ticks);
         smp.push_back(line);
         if (smp.size() == fl) begin
            checks++;
            avail = (inst == 0) ? exp0.size() : exp1.size();
            if (avail == 0) begin
               errors++;
               $display("FAIL frame%0d unexpected frame got_start_tick=%0d want=none", inst, ticks);
            end else begin
               if (inst == 0) want = exp0.pop_front();
               else want = exp1.pop_front();
               bad = 0;
               got = '0;
               for (int i = 0; i < fl; i++) begin
                  int b;
                  bit e;
                  b = i / OS;
                  if (b == 0) e = 1'b0;
                  else if (b <= db) e = want[b-1];
                  else e = 1'b1;
                  if (smp[i] != e) bad++;
               end
               for (int b = 0; b < db; b++) got[b] = smp[(b + 1) * OS + OS / 2];
               if (bad != 0) begin
                  errors++;
                  $display("FAIL frame%0d got=%02h want=%02h bad_ticks=%0d", inst, got, want, bad);
               end
            end
            smp.delete();
         end
      end
   endtask

   initial begin
      fork
         monitor(0);
         monitor(1);
      join_none
   end

   task automatic load_byte0(input logic [7:0] d, input bit expected);
      @(negedge clk);
      load0 = 1'b1;
      data0 = d;
      if (expected) exp0.push_back(d);
      @(negedge clk);
      load0 = 1'b0;
   endtask

   task automatic wait_rdy(input int inst);
      int n = 0;
      while (((inst == 0) ? rdy0 : rdy1) !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (((inst == 0) ? rdy0 : rdy1) !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL rdy_timeout%0d got=0 want=1", inst);
      end
   endtask

   task automatic wait_ticks(input int n);
      repeat (n) begin
         do @(posedge clk); while (!mclkx16);
      end
      #1;
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp0.size() != 0 || exp1.size() != 0) && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check("drain", exp0.size() + exp1.size(), 0);
      repeat (8) @(negedge clk);
   endtask

   task automatic driver(input int inst, input int count);
      logic [7:0] d;
      for (int k = 0; k < count; k++) begin
         repeat ($urandom_range(3, 0)) @(negedge clk);
         wait_rdy(inst);
         d = 8'($urandom);
         if (inst == 0) begin
            load0 = 1'b1;
            data0 = d;
            exp0.push_back(d);
         end else begin
            load1 = 1'b1;
            data1 = d[6:0];
            exp1.push_back({1'b0, d[6:0]});
         end
         @(negedge clk);
         if (inst == 0) load0 = 1'b0;
         else load1 = 1'b0;
      end
   endtask

   // Watchdog: never let a broken design hang the run.
   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0, s1;
      rst   = 1'b1;
      load0 = 1'b0;
      load1 = 1'b0;
      data0 = '0;
      data1 = '0;
      repeat (3) @(negedge clk);
      check("reset_tx", tx0, 1);
      check("reset_rdy", rdy0, 1);
      check("reset_busy", busy0, 0);
      check("reset_tx_7n2", tx1, 1);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // Reset with a byte in the holding register clears everything without a clock edge.
      load_byte0(8'h5A, 1'b0);
      check("held_rdy", rdy0, 0);
      check("held_busy", busy0, 1);
      rst = 1'b1;
      #1;
      check("async_rst_rdy", rdy0, 1);
      check("async_rst_busy", busy0, 0);
      check("async_rst_tx", tx0, 1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // Single byte 0x55 with mclkx16 every 4 clocks.
      load_byte0(8'h55, 1'b1);
      check("load_rdy", rdy0, 0);
      check("load_busy", busy0, 1);
      check("load_tx_idle", tx0, 1);
      wait_ticks(1);
      check("start_tx", tx0, 0);
      check("start_rdy", rdy0, 1);
      wait_ticks(159);
      check("last_stop_busy", busy0, 1);
      check("last_stop_tx", tx0, 1);
      wait_ticks(1);
      check("end_busy", busy0, 0);
      check("end_tx", tx0, 1);
      wait_drain();

      // Back-to-back: the second start bit follows the stop bit with no gap.
      starts0.delete();
      load_byte0(8'hA5, 1'b1);
      wait_rdy(0);
      load_byte0(8'h3C, 1'b1);
      wait_drain();
      check("b2b_frames", starts0.size(), 2);
      if (starts0.size() >= 2) begin
         s0 = starts0.pop_front();
         s1 = starts0.pop_front();
         check("b2b_spacing", s1 - s0, 160);
      end

      // Overrun: with 0x22 waiting behind 0x11, a further load of 0x33 is dropped.
      load_byte0(8'h11, 1'b1);
      wait_rdy(0);
      @(negedge clk);
      load0 = 1'b1;
      data0 = 8'h22;
      exp0.push_back(8'h22);
      @(negedge clk);
      data0 = 8'h33;
      check("overrun_rdy", rdy0, 0);
      @(negedge clk);
      load0 = 1'b0;
      wait_drain();

      // Abort mid-frame, then a clean 0xFF frame.
      load_byte0(8'h00, 1'b0);
      wait_rdy(0);
      wait_ticks(50);
      check("abort_pre_tx", tx0, 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_tx", tx0, 1);
      check("abort_busy", busy0, 0);
      check("abort_rdy", rdy0, 1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      load_byte0(8'hFF, 1'b1);
      wait_drain();

      // Random bytes on both configurations with random baud-enable gaps.
      gap_lo = 1;
      gap_hi = 6;
      fork
         driver(0, 15);
         driver(1, 15);
      join
      wait_drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
